// File: rtl/uart_tx_if.sv
// Byte handshake and serial-line bundle for uart_tx_buffered.
// The master side offers bytes and watches the line; the slave side is the transmitter.
interface uart_tx_if;
    logic [7:0] tx_data;   // byte to send, sampled when in_flag & tx_ready
    logic       in_flag;   // valid strobe for tx_data
    logic       tx_ready;  // holding register empty
    logic       tx;        // serial line, idles high
    logic       tx_done;   // one-cycle pulse on the last cycle of each stop bit

    modport master (output tx_data, in_flag, input  tx_ready, tx, tx_done);
    modport slave  (input  tx_data, in_flag, output tx_ready, tx, tx_done);
endinterface

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter, LSB first.
// A one-deep holding register sits in front of the shift register, so a byte
// refilled during a frame is loaded on the last stop-bit cycle and the next
// start bit follows with no idle gap.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit (11-bit frame).
module uart_tx_buffered #(
    parameter int MAX_CNT = 5208  // clocks per bit, >= 2
) (
    input  logic clk,
    input  logic rstn,            // synchronous, active-low
    uart_tx_if.slave bus
);

    localparam int CW = (MAX_CNT > 2) ? $clog2(MAX_CNT) : 1;
    localparam logic [CW-1:0] LAST = CW'(MAX_CNT - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   baud_cnt, baud_n;
    logic [2:0]      bit_cnt, bit_n;
    logic [7:0]      shift, shift_n;
    logic [7:0]      hold, hold_n;
    logic            hold_full, hold_full_n;
    logic            tx_q, tx_n;
    logic            done;
    logic            load;
    logic            accept;
    logic            bit_end;
    logic [2:0]      next_bit;

    assign accept   = bus.in_flag & ~hold_full;
    assign bit_end  = (baud_cnt == LAST);
    assign next_bit = bit_cnt + 3'd1;

    assign bus.tx_ready = ~hold_full;
    assign bus.tx       = tx_q;
    assign bus.tx_done  = done;

    // Next-state, next-line-level and handshake decode.
    always_comb begin
        // NOTE: every signal gets a default before the case; a missed branch would otherwise infer a latch.
        state_n     = state;
        baud_n      = baud_cnt;
        bit_n       = bit_cnt;
        shift_n     = shift;
        hold_n      = hold;
        hold_full_n = hold_full;
        tx_n        = tx_q;
        done        = 1'b0;
        load        = 1'b0;

        if (state != IDLE) begin
            baud_n = bit_end ? '0 : baud_cnt + ONE;
        end

        case (state)
            IDLE: begin
                if (hold_full) load = 1'b1;
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    bit_n   = 3'd0;
                    tx_n    = shift[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
                        tx_n    = ^shift;
`else
                        state_n = STOP;
                        tx_n    = 1'b1;
`endif
                    end else begin
                        bit_n = next_bit;
                        tx_n  = shift[next_bit];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_n = STOP;
                    tx_n    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    done = 1'b1;
                    if (hold_full) load = 1'b1;
                    else           state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // Load needs a full hold and accept needs an empty one, so they never collide.
        if (load) begin
            shift_n     = hold;
            hold_full_n = 1'b0;
            state_n     = START;
            tx_n        = 1'b0;
            baud_n      = '0;
        end
        if (accept) begin
            hold_n      = bus.tx_data;
            hold_full_n = 1'b1;
        end
    end

    // Control state with synchronous reset; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (!rstn) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= 3'd0;
            hold_full <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state     <= state_n;
            baud_cnt  <= baud_n;
            bit_cnt   <= bit_n;
            hold_full <= hold_full_n;
            tx_q      <= tx_n;
        end
    end

    // Byte storage; contents are only ever read while hold_full/state say they are valid.
    always_ff @(posedge clk) begin
        // NOTE: data registers are deliberately left out of reset; the qualifying flags are reset instead.
        hold  <= hold_n;
        shift <= shift_n;
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed self-checking bench for uart_tx_buffered with MAX_CNT=16.
// Sample point is 1 time unit after each rising edge; inputs change there too,
// so the DUT sees them at the following edge.
module tb_uart_tx_buffered;

    localparam int M = 16;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_LEN = FRAME_BITS * M;

    logic clk;
    logic rstn;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    uart_tx_if bus ();

    uart_tx_buffered #(.MAX_CNT(M)) u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Expected line level for bit slot idx of a frame carrying b.
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Offer b from idle; ends on the first start-bit cycle.
    task automatic send_byte(input logic [7:0] b);
        check("ready_before_send", 32'(bus.tx_ready), 32'd1);
        bus.tx_data = b;
        bus.in_flag = 1'b1;
        step();
        check("ready_after_accept", 32'(bus.tx_ready), 32'd0);
        check("line_idle_at_accept", 32'(bus.tx), 32'd1);
        bus.in_flag = 1'b0;
        bus.tx_data = ~b;  // must not disturb the accepted byte
        step();
        check("ready_after_load", 32'(bus.tx_ready), 32'd1);
    endtask

    // Checks tx and tx_done on every cycle of one frame, starting on its first
    // start-bit cycle and ending on the tx_done cycle. Optionally refills the
    // hold register at inj_at and offers a byte that must be dropped at drop_at.
    task automatic run_frame(input logic [7:0] b,
                             input int inj_at, input logic [7:0] inj_data,
                             input int drop_at, input logic [7:0] drop_data);
        for (int i = 0; i < FRAME_LEN; i++) begin
            check("frame_line", {30'd0, bus.tx, bus.tx_done},
                  {30'd0, frame_bit(b, i / M), 1'(i == FRAME_LEN - 1)});
            if (inj_at >= 0 && i == inj_at) begin
                check("refill_ready", 32'(bus.tx_ready), 32'd1);
                bus.tx_data = inj_data;
                bus.in_flag = 1'b1;
            end
            if (inj_at >= 0 && i == inj_at + 1) begin
                check("refill_taken", 32'(bus.tx_ready), 32'd0);
                bus.in_flag = 1'b0;
                bus.tx_data = 8'h00;
            end
            if (drop_at >= 0 && i == drop_at) begin
                check("drop_ready_low", 32'(bus.tx_ready), 32'd0);
                bus.tx_data = drop_data;
                bus.in_flag = 1'b1;
            end
            if (drop_at >= 0 && i == drop_at + 1) begin
                check("drop_still_full", 32'(bus.tx_ready), 32'd0);
                bus.in_flag = 1'b0;
                bus.tx_data = 8'h00;
            end
            if (i != FRAME_LEN - 1) step();
        end
    endtask

    // Line must stay idle with the hold register empty for n cycles.
    task automatic expect_idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check(tag, {29'd0, bus.tx, bus.tx_done, bus.tx_ready}, {29'd0, 3'b101});
            step();
        end
    endtask

    initial begin
        int t_done1;
        int t_done2;

        // Test 1: reset with in_flag held high must not accept anything.
        rstn        = 1'b0;
        bus.in_flag = 1'b1;
        bus.tx_data = 8'h99;
        step();
        step();
        check("reset_tx", 32'(bus.tx), 32'd1);
        check("reset_ready", 32'(bus.tx_ready), 32'd1);
        check("reset_done", 32'(bus.tx_done), 32'd0);
        rstn        = 1'b1;
        bus.in_flag = 1'b0;
        step();
        expect_idle("post_reset_idle", 2 * M);

        // Test 2: single byte 0x55.
        send_byte(8'h55);
        run_frame(8'h55, -1, 8'h00, -1, 8'h00);
        step();
        expect_idle("idle_after_55", M);

        // Tests 3 and 4: 0x00 with 0xFF refilled mid-frame, 0xA5 offered while full.
        send_byte(8'h00);
        run_frame(8'h00, 19, 8'hFF, 40, 8'hA5);
        t_done1 = cyc;
        step();
        run_frame(8'hFF, -1, 8'h00, -1, 8'h00);
        t_done2 = cyc;
        check("done_spacing", 32'(t_done2 - t_done1), 32'(FRAME_LEN));
        step();
        expect_idle("idle_after_ff", 2 * M);

        // Test 5: reset during data bit 3 of 0xF0 aborts the frame.
        send_byte(8'hF0);
        for (int i = 0; i < 4 * M + 5; i++) begin
            check("abort_pre_line", 32'(bus.tx), 32'(frame_bit(8'hF0, i / M)));
            step();
        end
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        check("abort_tx", 32'(bus.tx), 32'd1);
        check("abort_ready", 32'(bus.tx_ready), 32'd1);
        check("abort_done", 32'(bus.tx_done), 32'd0);
        expect_idle("abort_idle", FRAME_LEN);
        send_byte(8'h3C);
        run_frame(8'h3C, -1, 8'h00, -1, 8'h00);
        step();
        expect_idle("idle_after_3c", M);

        // Test 6: bytes 0..7 back to back via hold refill.
        send_byte(8'd0);
        for (int k = 0; k < 8; k++) begin
            if (k < 7) run_frame(8'(k), 3, 8'(k + 1), -1, 8'h00);
            else       run_frame(8'(k), -1, 8'h00, -1, 8'h00);
            step();
        end
        expect_idle("idle_after_burst", 2 * M);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
